hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 17, meaning cycles from md_start to md_done for a multiply.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 33, meaning cycles from md_start to md_done for a divide.
REQ-003 Port clock  input  1  the single rising-edge clock.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the clock's rising edge.
REQ-005 Port fd_insn  input  32  the instruction in the F/D latch.
REQ-006 Port dx_insn  input  32  the instruction in the D/X latch.
REQ-007 Port flush  input  1  branch/jump taken; squashes F/D and D/X.
REQ-008 Port stall_fd  output  1  freezes the PC and the F/D latch.
REQ-009 Port bubble_dx  output  1  loads a nop into D/X on the next edge.
REQ-010 Port md_start  output  1  one-cycle pulse that starts the multdiv unit.
REQ-011 Port md_is_div  output  1  operation select, valid with md_start.
REQ-012 Port md_busy  output  1  a multdiv operation is in flight.
REQ-013 Port md_done  output  1  one-cycle pulse; the multdiv result writes md_rd this cycle.
REQ-014 Port md_rd  output  5  destination register of the in-flight multdiv.

Function
REQ-015 Decode fields SHALL be: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
REQ-016 Multiply SHALL be opcode 00000 with ALU op 00110; divide SHALL be opcode 00000 with ALU op 00111.
REQ-017 Read registers of fd_insn SHALL be decoded as follows.
- R-type: rs and rt.
- sw (00111), bne (00010), blt (00110): rd and rs.
- jr (00100): rd.
- bex (10110): r30.
- All other opcodes: rs only.
REQ-018 Register 0 SHALL never cause a hazard.
REQ-019 Load-use: when dx_insn is lw (01000), its rd is read by fd_insn and flush=0, stall_fd and bubble_dx SHALL both be 1 for exactly that cycle; the next cycle resolves through normal bypassing.
REQ-020 The FSM SHALL have two states, IDLE and BUSY, and a down-counter of width ceil(log2(DIV_CYCLES)).
REQ-021 IDLE -> BUSY: when dx_insn is a mul or div and flush=0, the block SHALL pulse md_start, set md_is_div, capture md_rd=dx rd, and load the counter with the latency minus 1.
REQ-022 In BUSY the counter SHALL decrement each cycle; at counter 0 the block SHALL pulse md_done and return to IDLE on the next edge.
REQ-023 While BUSY, stall_fd and bubble_dx SHALL be 1 when fd_insn has any of the following hazards.
- It reads md_rd.
- It writes md_rd (WAW).
- It is itself a mul or div.
REQ-024 In the md_done cycle, the block SHALL release the stall for that same cycle.
REQ-025 A mul or div that reaches D/X while BUSY SHALL be impossible by REQ-023; if it occurs anyway, the block SHALL ignore it and keep the current operation.
REQ-026 flush SHALL force stall_fd=0 and bubble_dx=0 and SHALL NOT start a new operation.
REQ-027 flush SHALL NOT abort an operation already BUSY.
REQ-028 md_busy SHALL be 1 exactly while in state BUSY.
REQ-029 The block SHALL consider one hazard source at a time: a load-use hazard and a BUSY hazard in the same cycle SHALL produce a single stall.

Reset
REQ-030 On reset=1 at the clock edge, the state SHALL become IDLE and the counter and md_rd SHALL become 0.
REQ-031 After that reset edge, md_busy, md_done, md_start and md_is_div SHALL be 0.
REQ-032 stall_fd and bubble_dx SHALL be 0 while reset=1, regardless of insn inputs.
REQ-033 Reset mid-operation SHALL abandon the operation with no md_done.

Structure
REQ-034 Opcode constants, ALU-op constants, the r30/r31 indices and the FSM state encoding SHALL live in the shared processor package.
REQ-035 Instruction field and read-register decode SHALL be one sub-module, insn_regs_decode, instantiated once for fd_insn and once for dx_insn.

Verification
REQ-036 dx=lw r5 and fd=add r6,r5,r7 -> stall_fd=1 and bubble_dx=1 for one cycle, then 0.
REQ-037 dx=lw r0 and fd reads r0 -> no stall.
REQ-038 dx=mul r4 -> md_start pulse at cycle 0; md_busy=1; md_done at cycle 16 (MUL_CYCLES=17); md_busy=0 at cycle 17.
REQ-039 div r9 BUSY and fd=add r1,r9,r2 -> stalled until the md_done cycle (cycle 32), released that cycle; an fd not using r9 is never stalled.
REQ-040 mul r3 BUSY, fd=sw r3 and flush=1 -> stall_fd=0 and md_busy stays 1; with flush=1 and dx=mul -> no md_start.
REQ-041 reset at cycle 5 of a div -> IDLE next cycle, md_busy=0, and no md_done ever.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared processor constants: opcodes, ALU ops, special register indices and
// the multdiv FSM state encoding.
package hazard_stall_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [4:0] REG_R0   = 5'd0;
    localparam logic [4:0] REG_R30  = 5'd30;
    localparam logic [4:0] REG_R31  = 5'd31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Register 0 is hardwired, so it can never be the subject of a hazard.
    function automatic logic reads_reg(input logic [4:0] read_a,
                                       input logic [4:0] read_b,
                                       input logic [4:0] r);
        return (r != REG_R0) && ((read_a == r) || (read_b == r));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_regs.sv
// Instruction field decode: which registers an instruction reads and writes,
// and whether it is a multiply or divide.
module insn_regs_decode
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [31:0] insn,
    output logic [4:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  read_a,
    output logic [4:0]  read_b,
    output logic [4:0]  dest,
    output logic        is_mul,
    output logic        is_div
);

    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] alu_op;
    logic       unused_bits;

    assign opcode      = insn[31:27];
    assign rd          = insn[26:22];
    assign rs          = insn[21:17];
    assign rt          = insn[16:12];
    assign alu_op      = insn[6:2];
    assign unused_bits = ^{insn[11:7], insn[1:0]};

    assign is_mul = (opcode == OP_RTYPE) && (alu_op == ALU_MUL);
    assign is_div = (opcode == OP_RTYPE) && (alu_op == ALU_DIV);

    // Unused read slots are parked on r0 so they never match a hazard.
    always_comb begin
        read_a = REG_R0;
        read_b = REG_R0;
        case (opcode)
            OP_RTYPE: begin
                read_a = rs;
                read_b = rt;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                read_a = rd;
                read_b = rs;
            end
            OP_JR:   read_a = rd;
            OP_BEX:  read_a = REG_R30;
            default: read_a = rs;
        endcase
    end

    always_comb begin
        dest = REG_R0;
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW: dest = rd;
            OP_JAL:                   dest = REG_R31;
            OP_SETX:                  dest = REG_R30;
            default:                  dest = REG_R0;
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls plus sequencing of the
// multi-cycle multdiv unit and the stalls it imposes on dependent instructions.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 17,
    parameter int DIV_CYCLES = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    input  logic        flush,
    output logic        stall_fd,
    output logic        bubble_dx,
    output logic        md_start,
    output logic        md_is_div,
    output logic        md_busy,
    output logic        md_done,
    output logic [4:0]  md_rd
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state;
    logic [CNT_W-1:0] count;

    logic [4:0] fd_opcode, fd_rd, fd_read_a, fd_read_b, fd_dest;
    logic [4:0] dx_opcode, dx_rd, dx_read_a, dx_read_b, dx_dest;
    logic       fd_is_mul, fd_is_div, dx_is_mul, dx_is_div;
    logic       load_use, busy_hazard, stall;
    logic       unused_fields;

    insn_regs_decode u_fd_decode (
        .insn   (fd_insn),
        .opcode (fd_opcode),
        .rd     (fd_rd),
        .read_a (fd_read_a),
        .read_b (fd_read_b),
        .dest   (fd_dest),
        .is_mul (fd_is_mul),
        .is_div (fd_is_div)
    );

    insn_regs_decode u_dx_decode (
        .insn   (dx_insn),
        .opcode (dx_opcode),
        .rd     (dx_rd),
        .read_a (dx_read_a),
        .read_b (dx_read_b),
        .dest   (dx_dest),
        .is_mul (dx_is_mul),
        .is_div (dx_is_div)
    );

    assign unused_fields = ^{fd_opcode, fd_rd, dx_read_a, dx_read_b, dx_dest};

    assign md_busy = (state == ST_BUSY);
    assign md_done = (state == ST_BUSY) && (count == '0);

    // The done cycle already forwards the result, so dependents may proceed.
    assign load_use    = (dx_opcode == OP_LW) && reads_reg(fd_read_a, fd_read_b, dx_rd);
    assign busy_hazard = md_busy && !md_done &&
                         (reads_reg(fd_read_a, fd_read_b, md_rd) ||
                          ((fd_dest != REG_R0) && (fd_dest == md_rd)) ||
                          fd_is_mul || fd_is_div);

    assign stall     = !reset && !flush && (load_use || busy_hazard);
    assign stall_fd  = stall;
    assign bubble_dx = stall;

    // A mul/div showing up in D/X while busy is ignored; flush never aborts.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            md_rd     <= REG_R0;
            md_start  <= 1'b0;
            md_is_div <= 1'b0;
        end else begin
            md_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((dx_is_mul || dx_is_div) && !flush) begin
                        state     <= ST_BUSY;
                        md_start  <= 1'b1;
                        md_is_div <= dx_is_div;
                        md_rd     <= dx_rd;
                        count     <= dx_is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with the default
// 17-cycle multiply and 33-cycle divide latencies.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_insn = '0;
    logic [31:0] dx_insn = '0;
    logic        flush = 1'b0;
    logic        stall_fd, bubble_dx, md_start, md_is_div, md_busy, md_done;
    logic [4:0]  md_rd;

    int checks = 0;
    int passed = 0;

    localparam logic [31:0] NOP = 32'd0;

    hazard_stall_ctrl #(.MUL_CYCLES(17), .DIV_CYCLES(33)) dut (
        .clock     (clock),
        .reset     (reset),
        .fd_insn   (fd_insn),
        .dx_insn   (dx_insn),
        .flush     (flush),
        .stall_fd  (stall_fd),
        .bubble_dx (bubble_dx),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_rd     (md_rd)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] alu);
        return {OP_RTYPE, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_type(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs);
        return {op, rd, rs, 17'd4};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx, input logic fl);
        fd_insn = fd;
        dx_insn = dx;
        flush   = fl;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!md_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(r_type(5'd6, 5'd5, 5'd7, 5'd0), i_type(OP_LW, 5'd5, 5'd2), 1'b0);
        @(negedge clock);
        checks++; if (stall_fd !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall_fd); else passed++;
        tick();
        @(negedge clock);
        checks++; if (bubble_dx !== 1'b0) $display("[TB] FAIL reset_bubble: got %b expected 0", bubble_dx); else passed++;
        checks++; if ({md_busy, md_done, md_start, md_is_div} !== 4'b0000)
            $display("[TB] FAIL reset_md_flags: got %b expected 0000", {md_busy, md_done, md_start, md_is_div}); else passed++;
        checks++; if (md_rd !== 5'd0) $display("[TB] FAIL reset_md_rd: got %0d expected 0", md_rd); else passed++;
        tick();
        reset = 1'b0;
        applyStimulus(NOP, NOP, 1'b0);
    endtask

    task automatic test_load_use();
        applyStimulus(r_type(5'd6, 5'd5, 5'd7, 5'd0), i_type(OP_LW, 5'd5, 5'd2), 1'b0);
        @(negedge clock);
        checks++; if ({stall_fd, bubble_dx} !== 2'b11) $display("[TB] FAIL lu_stall: got %b expected 11", {stall_fd, bubble_dx}); else passed++;
        tick();
        applyStimulus(r_type(5'd6, 5'd5, 5'd7, 5'd0), NOP, 1'b0);
        @(negedge clock);
        checks++; if ({stall_fd, bubble_dx} !== 2'b00) $display("[TB] FAIL lu_release: got %b expected 00", {stall_fd, bubble_dx}); else passed++;
        tick();
        applyStimulus(i_type(OP_SW, 5'd8, 5'd3), i_type(OP_LW, 5'd8, 5'd1), 1'b0);
        @(negedge clock);
        checks++; if (stall_fd !== 1'b1) $display("[TB] FAIL lu_sw_rd: got %b expected 1", stall_fd); else passed++;
        tick();
        applyStimulus(i_type(OP_ADDI, 5'd1, 5'd8), i_type(OP_LW, 5'd8, 5'd1), 1'b0);
        @(negedge clock);
        checks++; if (stall_fd !== 1'b1) $display("[TB] FAIL lu_addi_rs: got %b expected 1", stall_fd); else passed++;
        tick();
        applyStimulus(i_type(OP_JR, 5'd31, 5'd0), i_type(OP_LW, 5'd31, 5'd1), 1'b0);
        @(negedge clock);
        checks++; if (stall_fd !== 1'b1) $display("[TB] FAIL lu_jr_rd: got %b expected 1", stall_fd); else passed++;
        tick();
        applyStimulus(i_type(OP_BEX, 5'd0, 5'd0), i_type(OP_LW, 5'd30, 5'd1), 1'b0);
        @(negedge clock);
        checks++; if (stall_fd !== 1'b1) $display("[TB] FAIL lu_bex_r30: got %b expected 1", stall_fd); else passed++;
        tick();
        applyStimulus(i_type(OP_ADDI, 5'd8, 5'd2), i_type(OP_LW, 5'd8, 5'd1), 1'b0);
        @(negedge clock);
        checks++; if (stall_fd !== 1'b0) $display("[TB] FAIL lu_no_read: got %b expected 0", stall_fd); else passed++;
        tick();
        applyStimulus(r_type(5'd6, 5'd5, 5'd7, 5'd0), i_type(OP_LW, 5'd5, 5'd2), 1'b1);
        @(negedge clock);
        checks++; if ({stall_fd, bubble_dx} !== 2'b00) $display("[TB] FAIL lu_flush: got %b expected 00", {stall_fd, bubble_dx}); else passed++;
        tick();
        applyStimulus(NOP, NOP, 1'b0);
    endtask

    task automatic test_load_use_r0();
        applyStimulus(r_type(5'd6, 5'd0, 5'd0, 5'd0), i_type(OP_LW, 5'd0, 5'd3), 1'b0);
        @(negedge clock);
        checks++; if (stall_fd !== 1'b0) $display("[TB] FAIL lu_r0: got %b expected 0", stall_fd); else passed++;
        tick();
        applyStimulus(NOP, NOP, 1'b0);
    endtask

    task automatic test_mul_timing();
        applyStimulus(NOP, r_type(5'd4, 5'd1, 5'd2, ALU_MUL), 1'b0);
        @(negedge clock);
        checks++; if (md_start !== 1'b0) $display("[TB] FAIL mul_pre_start: got %b expected 0", md_start); else passed++;
        tick();
        applyStimulus(NOP, NOP, 1'b0);
        @(negedge clock);
        checks++; if ({md_start, md_busy, md_is_div} !== 3'b110) $display("[TB] FAIL mul_start: got %b expected 110", {md_start, md_busy, md_is_div}); else passed++;
        checks++; if (md_rd !== 5'd4) $display("[TB] FAIL mul_rd: got %0d expected 4", md_rd); else passed++;
        for (int c = 1; c <= 16; c++) begin
            tick();
            @(negedge clock);
            checks++; if ({md_start, md_busy, md_done} !== {1'b0, 1'b1, (c == 16)})
                $display("[TB] FAIL mul_cycle%0d: got %b expected %b", c, {md_start, md_busy, md_done}, {1'b0, 1'b1, (c == 16)}); else passed++;
        end
        tick();
        @(negedge clock);
        checks++; if ({md_busy, md_done} !== 2'b00) $display("[TB] FAIL mul_end: got %b expected 00", {md_busy, md_done}); else passed++;
    endtask

    task automatic test_div_stall();
        logic [31:0] fd;
        logic        exp_stall;
        applyStimulus(NOP, r_type(5'd9, 5'd3, 5'd4, ALU_DIV), 1'b0);
        tick();
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) tick();
            case (c % 4)
                0:       fd = r_type(5'd1, 5'd9, 5'd2, 5'd0);
                1:       fd = r_type(5'd1, 5'd2, 5'd3, 5'd0);
                2:       fd = i_type(OP_ADDI, 5'd9, 5'd1);
                default: fd = r_type(5'd10, 5'd1, 5'd2, ALU_MUL);
            endcase
            exp_stall = ((c % 4) != 1) && (c < 32);
            applyStimulus(fd, (c == 10) ? r_type(5'd7, 5'd1, 5'd2, ALU_MUL) : NOP, 1'b0);
            @(negedge clock);
            checks++; if ({stall_fd, bubble_dx} !== {exp_stall, exp_stall})
                $display("[TB] FAIL div_stall_c%0d: got %b expected %b", c, {stall_fd, bubble_dx}, {exp_stall, exp_stall}); else passed++;
            checks++; if ({md_done, md_start, md_is_div, md_rd} !== {(c == 32), (c == 0), 1'b1, 5'd9})
                $display("[TB] FAIL div_state_c%0d: got %b expected %b", c, {md_done, md_start, md_is_div, md_rd}, {(c == 32), (c == 0), 1'b1, 5'd9}); else passed++;
        end
        tick();
        applyStimulus(NOP, NOP, 1'b0);
        @(negedge clock);
        checks++; if (md_busy !== 1'b0) $display("[TB] FAIL div_end_busy: got %b expected 0", md_busy); else passed++;
    endtask

    task automatic test_flush();
        logic ok;
        applyStimulus(NOP, r_type(5'd3, 5'd1, 5'd2, ALU_MUL), 1'b0);
        tick();
        applyStimulus(i_type(OP_SW, 5'd3, 5'd1), NOP, 1'b1);
        @(negedge clock);
        checks++; if ({stall_fd, bubble_dx, md_busy} !== 3'b001) $display("[TB] FAIL flush_busy_stall: got %b expected 001", {stall_fd, bubble_dx, md_busy}); else passed++;
        tick();
        @(negedge clock);
        checks++; if (md_busy !== 1'b1) $display("[TB] FAIL flush_no_abort: got %b expected 1", md_busy); else passed++;
        flush = 1'b0;
        #1;
        checks++; if (stall_fd !== 1'b1) $display("[TB] FAIL flush_off_stall: got %b expected 1", stall_fd); else passed++;
        tick();
        applyStimulus(NOP, NOP, 1'b0);
        wait_idle(ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL flush_drain_timeout: got %b expected 1", ok); else passed++;
        applyStimulus(NOP, r_type(5'd5, 5'd1, 5'd2, ALU_MUL), 1'b1);
        tick();
        applyStimulus(NOP, NOP, 1'b0);
        @(negedge clock);
        checks++; if ({md_start, md_busy} !== 2'b00) $display("[TB] FAIL flush_no_start: got %b expected 00", {md_start, md_busy}); else passed++;
    endtask

    task automatic test_back_to_back();
        logic ok;
        applyStimulus(NOP, r_type(5'd4, 5'd1, 5'd2, ALU_MUL), 1'b0);
        tick();
        applyStimulus(r_type(5'd6, 5'd4, 5'd5, 5'd0), i_type(OP_LW, 5'd5, 5'd1), 1'b0);
        @(negedge clock);
        checks++; if ({stall_fd, bubble_dx} !== 2'b11) $display("[TB] FAIL b2b_single_stall: got %b expected 11", {stall_fd, bubble_dx}); else passed++;
        tick();
        applyStimulus(NOP, NOP, 1'b0);
        wait_idle(ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL b2b_drain_timeout: got %b expected 1", ok); else passed++;
    endtask

    task automatic test_reset_mid_div();
        logic done_seen;
        applyStimulus(NOP, r_type(5'd9, 5'd3, 5'd4, ALU_DIV), 1'b0);
        tick();
        applyStimulus(NOP, NOP, 1'b0);
        for (int c = 1; c <= 5; c++) tick();
        @(negedge clock);
        checks++; if ({md_busy, md_rd} !== {1'b1, 5'd9}) $display("[TB] FAIL rst_mid_pre: got %b expected %b", {md_busy, md_rd}, {1'b1, 5'd9}); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if ({md_busy, md_done, md_rd} !== 7'd0) $display("[TB] FAIL rst_mid_idle: got %b expected 0", {md_busy, md_done, md_rd}); else passed++;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (md_done) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) $display("[TB] FAIL rst_mid_no_done: got %b expected 0", done_seen); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_use_r0();
        test_mul_timing();
        test_div_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
